m_div_unit: RTL

//  Iterative radix-2 restoring divider; the division counterpart to the core ALU multiplier.

---
 rtl/m_div_unit.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/m_div_unit.sv
// m_div_unit: iterative radix-2 restoring divider for RV64M DIV/DIVU/REM/REMU.
// One quotient bit per cycle; start/busy/ready handshake with flush for pipeline kills.
// Divide-by-zero and signed overflow give the RISC-V results and never trap.
// Optional macro DIV_FAST_SPECIAL_EN: divide-by-zero, signed overflow and a zero
// dividend skip CALC and report after one cycle. When it is undefined, every
// operation takes the full WIDTH+2 cycles.
module m_div_unit #(
  parameter  int unsigned WIDTH = 64,
  localparam int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             flush,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX
  } state_e;

  localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   dvd_q, dvd_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   a_raw_q, a_raw_d;
  logic               q_neg_q, q_neg_d;
  logic               r_neg_q, r_neg_d;
  logic               div0_q, div0_d;
  logic               ovf_q, ovf_d;
  logic               busy_q, busy_d;
  logic               ready_q, ready_d;
  logic [WIDTH-1:0]   quot_q, quot_d;
  logic [WIDTH-1:0]   remo_q, remo_d;

  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_abs, b_abs;
  logic               is_div0, is_ovf, fast_skip;
  logic [WIDTH:0]     rem_ext;
  logic [WIDTH-1:0]   rem_sub;
  logic               rem_ge;

  // Next-state, datapath and registered-output logic for the whole divider.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    a_raw_d = a_raw_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    div0_d  = div0_q;
    ovf_d   = ovf_q;
    busy_d  = busy_q;
    ready_d = 1'b0;
    quot_d  = quot_q;
    remo_d  = remo_q;

    a_neg   = is_signed & op_a[WIDTH-1];
    b_neg   = is_signed & op_b[WIDTH-1];
    a_abs   = a_neg ? -op_a : op_a;
    b_abs   = b_neg ? -op_b : op_b;
    is_div0 = (op_b == '0);
    is_ovf  = is_signed && (op_a == MIN_NEG) && (op_b == '1);
`ifdef DIV_FAST_SPECIAL_EN
    fast_skip = is_div0 | is_ovf | (op_a == '0);
`else
    fast_skip = 1'b0;
`endif

    // Partial remainder is always below the divisor, so the low WIDTH bits of
    // the difference are exact whenever the subtraction is taken.
    rem_ext = {rem_q, dvd_q[WIDTH-1]};
    rem_ge  = (rem_ext >= {1'b0, dvs_q});
    rem_sub = rem_ext[WIDTH-1:0] - dvs_q;

    unique case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          a_raw_d = op_a;
          dvd_d   = a_abs;
          dvs_d   = b_abs;
          rem_d   = '0;
          q_neg_d = a_neg ^ b_neg;
          r_neg_d = a_neg;
          div0_d  = is_div0;
          ovf_d   = is_ovf;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = fast_skip ? S_FIX : S_CALC;
        end
      end
      S_CALC: begin
        if (flush) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          // One settle cycle after the last iteration keeps start-to-ready at WIDTH+2.
          state_d = S_FIX;
        end else begin
          rem_d = rem_ge ? rem_sub : rem_ext[WIDTH-1:0];
          dvd_d = {dvd_q[WIDTH-2:0], rem_ge};
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_FIX: begin
        if (flush) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          if (div0_q) begin
            quot_d = '1;
            remo_d = a_raw_q;
          end else if (ovf_q) begin
            quot_d = a_raw_q;
            remo_d = '0;
          end else begin
            quot_d = q_neg_q ? -dvd_q : dvd_q;
            remo_d = r_neg_q ? -rem_q : rem_q;
          end
          ready_d = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      a_raw_q <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      div0_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
      quot_q  <= '0;
      remo_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      a_raw_q <= a_raw_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      div0_q  <= div0_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
      quot_q  <= quot_d;
      remo_q  <= remo_d;
    end
  end

  assign busy      = busy_q;
  assign ready     = ready_q;
  assign quotient  = quot_q;
  assign remainder = remo_q;

endmodule
